// File: rtl/alu_operand_collect.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_collect
// Purpose  : Single-entry operand collector ahead of the ALU. Accepts one
//            decoded operation, reads A/B (and optionally C/D) over two
//            register-file read ports, then presents the complete bundle to
//            the ALU under a valid/ready handshake.
// Options  : ALU_COLLECT_BYPASS_EN adds a write-back bypass (wb_* ports) that
//            overrides register-file data per operand on an address match.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_collect #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   // upstream operation interface
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic                  in_floating,
   input  logic                  in_form,
   input  logic [1:0]            in_precision,
   input  logic                  in_use_cd,
   input  logic [REG_ADDR_W-1:0] in_ra,
   input  logic [REG_ADDR_W-1:0] in_rb,
   input  logic [REG_ADDR_W-1:0] in_rc,
   input  logic [REG_ADDR_W-1:0] in_rd,
   // register-file read ports (data returns combinationally)
   output logic [REG_ADDR_W-1:0] rf_raddr0,
   output logic [REG_ADDR_W-1:0] rf_raddr1,
   input  logic [DATA_W-1:0]     rf_rdata0,
   input  logic [DATA_W-1:0]     rf_rdata1,
`ifdef ALU_COLLECT_BYPASS_EN
   // write-back bypass
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
`endif
   // ALU bundle interface
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            alu_op,
   output logic                  alu_floating,
   output logic                  alu_form,
   output logic [1:0]            alu_precision,
   output logic [DATA_W-1:0]     alu_A,
   output logic [DATA_W-1:0]     alu_B,
   output logic [DATA_W-1:0]     alu_C,
   output logic [DATA_W-1:0]     alu_D
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD_AB = 2'd1,
      ST_RD_CD = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_accept;

   // latched request fields
   logic                  r_use_cd;
   logic [REG_ADDR_W-1:0] r_ra;
   logic [REG_ADDR_W-1:0] r_rb;
   logic [REG_ADDR_W-1:0] r_rc;
   logic [REG_ADDR_W-1:0] r_rd;

   // bundle registers
   logic [2:0]            r_op;
   logic                  r_floating;
   logic                  r_form;
   logic [1:0]            r_precision;
   logic [DATA_W-1:0]     r_a;
   logic [DATA_W-1:0]     r_b;
   logic [DATA_W-1:0]     r_c;
   logic [DATA_W-1:0]     r_d;

   // operand values to capture this cycle, after optional bypass
   logic [DATA_W-1:0]     w_opnd0;
   logic [DATA_W-1:0]     w_opnd1;

   assign w_accept = in_valid & in_ready;

   // State register; reset drops any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, handshake and read-address decode.
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      rf_raddr0    = '0;
      rf_raddr1    = '0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = ST_RD_AB;
            end
         end
         ST_RD_AB: begin
            rf_raddr0    = r_ra;
            rf_raddr1    = r_rb;
            w_next_state = r_use_cd ? ST_RD_CD : ST_HOLD;
         end
         ST_RD_CD: begin
            rf_raddr0    = r_rc;
            rf_raddr1    = r_rd;
            w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            // The slot frees the same cycle the ALU takes the bundle, so a
            // new operation can enter without a bubble in IDLE.
            in_ready  = out_ready;
            if (out_ready) begin
               w_next_state = in_valid ? ST_RD_AB : ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Per-port operand source: register file, or write-back data on a match.
   always_comb begin
      w_opnd0 = rf_rdata0;
      w_opnd1 = rf_rdata1;
`ifdef ALU_COLLECT_BYPASS_EN
      if (wb_valid && (wb_addr == rf_raddr0)) begin
         w_opnd0 = wb_data;
      end
      if (wb_valid && (wb_addr == rf_raddr1)) begin
         w_opnd1 = wb_data;
      end
`endif
   end

   // Request latch and operand capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_use_cd    <= 1'b0;
         r_ra        <= '0;
         r_rb        <= '0;
         r_rc        <= '0;
         r_rd        <= '0;
         r_op        <= '0;
         r_floating  <= 1'b0;
         r_form      <= 1'b0;
         r_precision <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_d         <= '0;
      end else begin
         if (w_accept) begin
            r_use_cd    <= in_use_cd;
            r_ra        <= in_ra;
            r_rb        <= in_rb;
            r_rc        <= in_rc;
            r_rd        <= in_rd;
            r_op        <= in_op;
            r_floating  <= in_floating;
            r_form      <= in_form;
            r_precision <= in_precision;
            // C/D stay zero for two-operand ops.
            r_c         <= '0;
            r_d         <= '0;
         end
         case (r_state)
            ST_RD_AB: begin
               r_a <= w_opnd0;
               r_b <= w_opnd1;
            end
            ST_RD_CD: begin
               r_c <= w_opnd0;
               r_d <= w_opnd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign alu_op        = r_op;
   assign alu_floating  = r_floating;
   assign alu_form      = r_form;
   assign alu_precision = r_precision;
   assign alu_A         = r_a;
   assign alu_B         = r_b;
   assign alu_C         = r_c;
   assign alu_D         = r_d;

endmodule
`default_nettype wire

// File: doc/alu_operand_collect.md
Name: alu_operand_collect

Overview:
- Issue stage directly upstream of the ALU.
- Accepts one decoded ALU operation with up to four source register indices.
- Reads the operands from the register file over two read-port cycles and holds the complete operand bundle (op, floating, form, precision, A–D) for the ALU under a valid/ready handshake.
- Single-entry collector: one operation in flight; a new one can be accepted in the same cycle the current one issues.

Parameters:
DATA_W, 32, operand width (matches ALU A/B/C/D).
REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream offers an operation
in_ready  output  1  collector can accept this cycle
in_op  input  3  ALU opcode
in_floating  input  1  float/integer select
in_form  input  1  ALU form select
in_precision  input  2  ALU precision
in_use_cd  input  1  1: op needs C and D; 0: only A and B
in_ra, in_rb, in_rc, in_rd  input  REG_ADDR_W  source register indices
rf_raddr0, rf_raddr1  output  REG_ADDR_W  register-file read addresses
rf_rdata0, rf_rdata1  input  DATA_W  read data, combinational from rf_raddr0/1 in the same cycle
out_valid  output  1  operand bundle valid
out_ready  input  1  ALU consumes bundle
alu_op  output  3  registered opcode
alu_floating  output  1  registered float select
alu_form  output  1  registered form select
alu_precision  output  2  registered precision
alu_A, alu_B, alu_C, alu_D  output  DATA_W  collected operands

Behaviour:
- States: IDLE, RD_AB, RD_CD, HOLD. Reset and clock are fixed: clk, rst synchronous active-high.
- Reset values: state=IDLE, out_valid=0, all alu_* outputs=0, latched indices=0, rf_raddr0/1=0.
- rst asserted mid-operation: collector returns to IDLE next edge and discards the operation; no partial issue.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready.
- On accept:
  - Latch op, floating, form, precision, use_cd and ra..rd; next state RD_AB.
  - alu_C and alu_D are cleared to 0.
- RD_AB:
  - rf_raddr0=ra, rf_raddr1=rb.
  - At the edge, alu_A<=rf_rdata0 and alu_B<=rf_rdata1.
  - Next state RD_CD if use_cd, else HOLD.
- RD_CD:
  - rf_raddr0=rc, rf_raddr1=rd.
  - At the edge, alu_C<=rf_rdata0 and alu_D<=rf_rdata1.
  - Next state HOLD.
- HOLD:
  - out_valid=1.
  - All alu_* outputs stable while out_valid & !out_ready.
  - On out_ready: next state RD_AB if a new op is accepted the same cycle, else IDLE.
- rf_raddr0/1 are 0 in IDLE and HOLD.
- Latency (accept edge = t):
  - use_cd=0: out_valid high from cycle t+2.
  - use_cd=1: out_valid high from cycle t+3.
- Throughput with back-to-back ops and out_ready=1:
  - use_cd=0: one op per 2 cycles.
  - use_cd=1: one op per 3 cycles.
- in_valid with in_ready=0: no state change; upstream must hold its fields.
- Source indices equal to one another: no special handling; each read is independent.

Optional Feature:
- Macro: ALU_COLLECT_BYPASS_EN.
- With the macro defined, add these ports:
  - wb_valid input 1
  - wb_addr input REG_ADDR_W
  - wb_data input DATA_W
- In RD_AB and RD_CD, each operand capture takes wb_data instead of rf_rdata when wb_valid=1 and wb_addr equals that operand's read address. The bypass applies per operand independently.
- Without the macro: the wb_* ports do not exist and operands always come from rf_rdata.
- Timing and handshake are identical in both builds.

Test Plan:
1. Reset, then accept op=3'b010, use_cd=0, ra=1, rb=2 with rf[1]=0x11, rf[2]=0x22 at t -> out_valid at t+2; alu_A=0x11, alu_B=0x22, alu_C=alu_D=0, alu_op=3'b010.
2. use_cd=1, ra..rd=4,5,6,7 with rf=0xA,0xB,0xC,0xD -> out_valid at t+3; A..D=0xA..0xD; precision, form and floating match the inputs.
3. Hold out_ready=0 for 5 cycles in HOLD -> outputs unchanged, in_ready=0. Raise out_ready together with in_valid for a new op -> accepted the same cycle; next state RD_AB; out_valid drops for one cycle.
4. Assert rst during RD_CD -> next cycle state=IDLE, out_valid=0, alu_A..D=0, in_ready=1. The first post-reset op issues with correct operands.
5. Stream 4 use_cd=0 ops with out_ready=1 -> out_valid pulses every 2 cycles; operands ordered and correct.
6. (ALU_COLLECT_BYPASS_EN) wb_valid=1, wb_addr=2, wb_data=0x99 during RD_AB for ra=2, rb=2 while rf[2]=0x22 -> alu_A=alu_B=0x99. Without the macro -> 0x22.
